// File: rtl/debug_inspector_if.sv
// Shared read bus between the debug inspector and its inspectable sources.
// The inspector drives one address and a one-hot read strobe; every source
// returns its read data on its own slice of mem_read_data.
interface debug_inspector_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int NUM_CHANNELS = 3
);
  logic [ADDR_WIDTH-1:0]              mem_address;
  logic [NUM_CHANNELS-1:0]            mem_read_enable;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] mem_read_data;

  modport master (
    output mem_address,
    output mem_read_enable,
    input  mem_read_data
  );

  modport slave (
    input  mem_address,
    input  mem_read_enable,
    output mem_read_data
  );
endinterface

// File: rtl/debug_inspector.sv
// Debug inspector: one shared, FSM-driven read port for all inspectable sources.
// Manual mode re-reads one address continuously; scan mode walks the whole
// address space, dwelling on each address. The last captured value is held on
// registered display outputs for the board display logic.
module debug_inspector #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int NUM_CHANNELS = 3,
  parameter int READ_LATENCY = 1,
  parameter int SCAN_DWELL   = 50000000,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [CH_W-1:0]       channel_select,
  input  logic [ADDR_WIDTH-1:0] manual_address,
  input  logic                  freeze,
  debug_inspector_if.master     mem_bus,
  output logic [CH_W-1:0]       display_channel,
  output logic [ADDR_WIDTH-1:0] display_address,
  output logic [DATA_WIDTH-1:0] display_value,
  output logic                  display_valid,
  output logic                  scan_wrap
);

  localparam int WAIT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int DWELL_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(READ_LATENCY - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DWELL - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DWELL} state_t;

  state_t                  state, next_state;
  logic [WAIT_W-1:0]       wait_count, wait_next;
  logic [DWELL_W-1:0]      dwell_count, dwell_next;
  logic [ADDR_WIDTH-1:0]   target_address, load_address;
  logic [CH_W-1:0]         target_channel;
  logic                    scan_active;
  logic [NUM_CHANNELS-1:0] read_enable_q, strobe_next;
  logic [DATA_WIDTH-1:0]   selected_data;
  logic                    load_target, wrap_next, capture;

  assign mem_bus.mem_address     = target_address;
  assign mem_bus.mem_read_enable = read_enable_q;

  // One-hot strobe for the requested channel; out-of-range selects give no strobe.
  always_comb begin
    strobe_next = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (channel_select == CH_W'(i)) strobe_next[i] = 1'b1;
    end
  end

  // Pick the in-flight channel's slice of the read bus; out-of-range reads as 0.
  always_comb begin
    selected_data = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (target_channel == CH_W'(i)) selected_data = mem_bus.mem_read_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and control; freeze only blocks new reads, an issued read always completes
  // and a frozen manual loop parks in IDLE until it is released.
  always_comb begin
    next_state   = state;
    wait_next    = wait_count;
    dwell_next   = dwell_count;
    load_target  = 1'b0;
    load_address = manual_address;
    wrap_next    = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (!freeze) begin
          next_state  = ISSUE;
          load_target = 1'b1;
        end
      end
      ISSUE: begin
        next_state = WAIT;
        wait_next  = '0;
      end
      WAIT: begin
        if (wait_count == WAIT_LAST) begin
          capture   = 1'b1;
          wait_next = '0;
          if (scan_active) begin
            next_state = DWELL;
            dwell_next = '0;
          end else if (freeze) begin
            next_state = IDLE;
          end else begin
            next_state  = ISSUE;
            load_target = 1'b1;
          end
        end else begin
          wait_next = wait_count + WAIT_W'(1);
        end
      end
      DWELL: begin
        if (!freeze) begin
          if (dwell_count == DWELL_LAST) begin
            next_state  = ISSUE;
            load_target = 1'b1;
            dwell_next  = '0;
            if (mode) begin
              load_address = target_address + ADDR_WIDTH'(1);
              wrap_next    = &target_address;
            end
          end else begin
            dwell_next = dwell_count + DWELL_W'(1);
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Counters, read target, strobe and display capture; reset drops any read in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_count      <= '0;
      dwell_count     <= '0;
      target_address  <= '0;
      target_channel  <= '0;
      scan_active     <= 1'b0;
      read_enable_q   <= '0;
      scan_wrap       <= 1'b0;
      display_channel <= '0;
      display_address <= '0;
      display_value   <= '0;
      display_valid   <= 1'b0;
    end else begin
      wait_count  <= wait_next;
      dwell_count <= dwell_next;
      scan_wrap   <= wrap_next;
      if (load_target) begin
        target_address <= load_address;
        target_channel <= channel_select;
        scan_active    <= mode;
        read_enable_q  <= strobe_next;
      end else begin
        read_enable_q <= '0;
      end
      if (capture) begin
        display_channel <= target_channel;
        display_address <= target_address;
        display_value   <= selected_data;
        display_valid   <= 1'b1;
      end
    end
  end

endmodule
